inext_accum_arbiter: RTL and testbench
======================================

# inext_accum_arbiter

Shared-resource controller that serializes read-modify-write accumulations into the i_next current memory on behalf of `numreq` synaptic processing units. Each unit presents a (dst_tag, weight) pair. The arbiter grants requesters round-robin, reads i_next[dst_tag], adds the weight with signed saturation, writes the result back and acknowledges the requester. Because only one accumulation is in flight at a time, concurrent units can never lose an update through an RMW race on the same neuron.

## Interface
Parameters:
- `numneurons`, 2: neurons addressed by i_next memory.
- `numwidth`, 16: data MSB index; all values are `numwidth+1` bits, signed two's complement.
- `tagbits`, 1: neuron tag width.
- `numreq`, 4: number of requesting synaptic units.
- `reqbits`, 2: width of the grant index; clog2(`numreq`).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `syn_reset_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  `numreq`  bit k high means requester k has a pending accumulation.
- `req_dst_tag`  in  `numreq*tagbits`  packed target tags; requester k occupies slice k.
- `req_weight`  in  `numreq*(numwidth+1)`  packed signed weights; requester k occupies slice k.
- `req_ack`  out  `numreq`  one-hot, one-cycle pulse when requester k's write commits.
- `mem_rd_en`  out  1  i_next read strobe.
- `mem_rd_tag`  out  `tagbits`  read address.
- `mem_rd_data`  in  `numwidth+1`  read data, valid exactly 1 cycle after `mem_rd_en`.
- `mem_wr_en`  out  1  i_next write strobe.
- `mem_wr_tag`  out  `tagbits`  write address.
- `mem_wr_data`  out  `numwidth+1`  write data.
- `busy`  out  1  high in every state except IDLE.
- `grant_idx`  out  `reqbits`  index of the current or last granted requester.
- `sat_sticky`  out  1  set when any accumulation saturates; cleared only by reset.

## Operation
- FSM states: IDLE, READ, ADD, WRITE.
- IDLE:
  - If any `req_valid` is high, select the winner round-robin, starting the search at `rr_ptr` and wrapping modulo `numreq`.
  - Latch the winner's tag and weight into internal registers, latch `grant_idx`, go to READ.
  - Otherwise stay in IDLE.
- READ: drive `mem_rd_en`=1 and `mem_rd_tag`=latched tag; go to ADD.
- ADD:
  - Capture `mem_rd_data` and compute sum = `mem_rd_data` + latched weight.
  - Positive overflow saturates to 2^numwidth−1; negative overflow saturates to −2^numwidth. Either case sets `sat_sticky`.
  - Register the result; go to WRITE.
- WRITE:
  - Drive `mem_wr_en`=1, `mem_wr_tag`=latched tag, `mem_wr_data`=result, and `req_ack[grant_idx]`=1.
  - Set `rr_ptr` = (`grant_idx`+1) mod `numreq`.
  - Arbitrate this cycle among `req_valid` with bit `grant_idx` masked out, since the acked requester still shows valid this cycle.
  - If a winner exists, latch it and go directly to READ. Otherwise go to IDLE.
- Requester contract:
  - Hold valid, tag and weight stable until `req_ack`.
  - May drop valid or present a new request in the cycle after `req_ack`.
  - Tag and weight changes after grant are ignored, because they are latched.
- `mem_rd_en`, `mem_wr_en` and `req_ack` are decoded from the registered state and latched registers only; they are never combinational from inputs.
- Multiple requests to the same tag are fully serialized. The WRITE of one accumulation always precedes the READ of the next by at least 1 cycle, which is correct for a synchronous write-first or read-first RAM.

## Timing
- Reset (`syn_reset_n` low at a clock edge): state=IDLE, `rr_ptr`=0, `grant_idx`=0, `busy`=0, `req_ack`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_rd_tag`=0, `mem_wr_tag`=0, `mem_wr_data`=0, `sat_sticky`=0.
- Reset mid-operation aborts with no write and no ack. A requester that was granted keeps its valid and is re-arbitrated after reset.
- Latency: `req_valid` sampled in IDLE at edge t; `mem_rd_en` high in cycle t+1; data captured at the end of t+2; `mem_wr_en` and `req_ack` high in cycle t+3.
- Throughput:
  - From IDLE, 4 cycles per accumulation.
  - Back-to-back (WRITE→READ), 3 cycles per accumulation.
  - With all requesters continuously valid, each is served once per `numreq` grants; there is no starvation.
- `req_ack` is never high for more than one bit or more than one cycle per grant.

## Test plan
- Single request, no overflow: numwidth=15, i_next[1]=100, req 2 sends tag=1, weight=−30 → `mem_wr_data`=70 to tag 1; `req_ack`=4'b0100 exactly 3 cycles after the first rd_en-1 cycle; `busy` low afterwards.
- Saturation: i_next[0]=32760, weight=+100 → write 32767, `sat_sticky`=1. Then i_next[0]=−32760, weight=−100 → write −32768, and `sat_sticky` stays 1.
- Round-robin fairness: all four requesters valid continuously with weight 1, same tag, initial 0 → grant order 0,1,2,3,0,…; after 8 acks the tag holds 8; 3 cycles between successive acks.
- Same-tag serialization: req 0 sends weight +5 and req 3 sends weight +7, both to tag 1, asserted in the same cycle, start value 10 → writes 15 then 22; the second read returns 15.
- Stability and masking: req 1 changes its weight after grant → the latched weight is used. Req 1 still valid in its WRITE cycle with no other requesters → no regrant that cycle; FSM goes to IDLE.
- Reset mid-op: assert `syn_reset_n`=0 during ADD → no `mem_wr_en`, no `req_ack`, and all outputs at their reset values next cycle.

Source files
------------

// File: rtl/inext_accum_arbiter.sv
// inext_accum_arbiter
// Serializes read-modify-write accumulations into the i_next current memory
// for numreq synaptic processing units. One accumulation is in flight at a
// time, so two units hitting the same neuron can never lose an update.
//
// Ports:
//   clk, syn_reset_n           clock, synchronous active-low reset
//   req_valid/dst_tag/weight   per-requester request, tag and signed weight (packed)
//   req_ack                    one-hot, one-cycle pulse when a requester's write commits
//   mem_rd_en/rd_tag/rd_data   i_next read port (data valid 1 cycle after rd_en)
//   mem_wr_en/wr_tag/wr_data   i_next write port
//   busy                       high whenever the FSM is not IDLE
//   grant_idx                  current or last granted requester
//   sat_sticky                 some accumulation saturated since reset
module inext_accum_arbiter #(
  parameter int numneurons = 2,
  parameter int numwidth   = 16,
  parameter int tagbits    = 1,
  parameter int numreq     = 4,
  parameter int reqbits    = 2
) (
  input  logic                            clk,
  input  logic                            syn_reset_n,
  input  logic [numreq-1:0]               req_valid,
  input  logic [numreq*tagbits-1:0]       req_dst_tag,
  input  logic [numreq*(numwidth+1)-1:0]  req_weight,
  output logic [numreq-1:0]               req_ack,
  output logic                            mem_rd_en,
  output logic [tagbits-1:0]              mem_rd_tag,
  input  logic [numwidth:0]               mem_rd_data,
  output logic                            mem_wr_en,
  output logic [tagbits-1:0]              mem_wr_tag,
  output logic [numwidth:0]               mem_wr_data,
  output logic                            busy,
  output logic [reqbits-1:0]              grant_idx,
  output logic                            sat_sticky
);

  localparam int DW = numwidth + 1;
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {numwidth{1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {numwidth{1'b0}}};

  // Configuration sanity: every neuron must be addressable by a tag and
  // every requester by a grant index.
  if (numneurons > (1 << tagbits)) begin : g_bad_tagbits
    $error("tagbits too small for numneurons");
  end
  if (numreq > (1 << reqbits)) begin : g_bad_reqbits
    $error("reqbits too small for numreq");
  end

  typedef enum logic [1:0] {IDLE, READ, ADD, WRITE} state_e;

  state_e               state_q, state_d;
  logic [reqbits-1:0]   rr_ptr_q, rr_ptr_d;
  logic [reqbits-1:0]   grant_q, grant_d;
  logic [tagbits-1:0]   tag_q, tag_d;
  logic [DW-1:0]        weight_q, weight_d;
  logic [DW-1:0]        result_q, result_d;
  logic                 sat_q, sat_d;

  // Unpack the flat request buses so the winner can be selected by index.
  logic [tagbits-1:0]   req_tag_arr [numreq];
  logic [DW-1:0]        req_wgt_arr [numreq];

  for (genvar k = 0; k < numreq; k++) begin : g_unpack
    assign req_tag_arr[k] = req_dst_tag[k*tagbits +: tagbits];
    assign req_wgt_arr[k] = req_weight[k*DW +: DW];
  end

  // Pointer that follows the requester being acknowledged.
  logic [reqbits-1:0] next_ptr;
  assign next_ptr = (grant_q == reqbits'(numreq - 1)) ? '0 : grant_q + 1'b1;

  // Round-robin search. In WRITE the acked requester still shows valid, so
  // its bit is masked and the search starts just past it.
  logic [numreq-1:0]  arb_mask;
  logic [reqbits-1:0] arb_start;
  logic [reqbits-1:0] cand;
  logic [reqbits-1:0] arb_idx;
  logic               arb_found;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    arb_mask  = req_valid;
    arb_start = rr_ptr_q;
    cand      = '0;
    arb_idx   = '0;
    arb_found = 1'b0;
    if (state_q == WRITE) begin
      arb_mask[grant_q] = 1'b0;
      arb_start         = next_ptr;
    end
    // Walk backwards so the candidate closest to arb_start wins last.
    for (int i = numreq - 1; i >= 0; i--) begin
      cand = reqbits'((int'(arb_start) + i) % numreq);
      if (arb_mask[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Signed add with one guard bit; overflow shows as guard != sign.
  logic [DW:0]   sum_ext;
  logic          sum_ovf;
  logic [DW-1:0] sum_sat;

  always_comb begin
    sum_ext = {mem_rd_data[DW-1], mem_rd_data} + {weight_q[DW-1], weight_q};
    sum_ovf = sum_ext[DW] ^ sum_ext[DW-1];
    sum_sat = sum_ext[DW-1:0];
    if (sum_ovf) sum_sat = sum_ext[DW] ? SAT_MIN : SAT_MAX;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    tag_d    = tag_q;
    weight_d = weight_q;
    result_d = result_q;
    sat_d    = sat_q;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d  = arb_idx;
          tag_d    = req_tag_arr[arb_idx];
          weight_d = req_wgt_arr[arb_idx];
          state_d  = READ;
        end
      end
      READ: state_d = ADD;
      ADD: begin
        result_d = sum_sat;
        sat_d    = sat_q | sum_ovf;
        state_d  = WRITE;
      end
      WRITE: begin
        rr_ptr_d = next_ptr;
        if (arb_found) begin
          grant_d  = arb_idx;
          tag_d    = req_tag_arr[arb_idx];
          weight_d = req_wgt_arr[arb_idx];
          state_d  = READ;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!syn_reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      tag_q    <= '0;
      weight_q <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      tag_q    <= tag_d;
      weight_q <= weight_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  // Outputs decode only registered state, never the request inputs.
  always_comb begin
    req_ack = '0;
    if (state_q == WRITE) req_ack[grant_q] = 1'b1;
  end

  assign mem_rd_en   = (state_q == READ);
  assign mem_rd_tag  = tag_q;
  assign mem_wr_en   = (state_q == WRITE);
  assign mem_wr_tag  = tag_q;
  assign mem_wr_data = result_q;
  assign busy        = (state_q != IDLE);
  assign grant_idx   = grant_q;
  assign sat_sticky  = sat_q;

endmodule

// File: tb/tb_inext_accum_arbiter.sv
// Directed testbench for inext_accum_arbiter with a 16-bit datapath.
// A small synchronous RAM stands in for i_next; expected values are
// hand-computed constants.
module tb_inext_accum_arbiter;

  localparam int NW   = 15;
  localparam int DW   = NW + 1;
  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 syn_reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_dst_tag;
  logic [NREQ*DW-1:0]   req_weight;
  logic [NREQ-1:0]      req_ack;
  logic                 mem_rd_en;
  logic                 mem_rd_tag;
  logic [DW-1:0]        mem_rd_data;
  logic                 mem_wr_en;
  logic                 mem_wr_tag;
  logic [DW-1:0]        mem_wr_data;
  logic                 busy;
  logic [1:0]           grant_idx;
  logic                 sat_sticky;

  always #5 clk = ~clk;

  inext_accum_arbiter #(
    .numneurons(2), .numwidth(NW), .tagbits(1), .numreq(NREQ), .reqbits(2)
  ) dut (
    .clk(clk), .syn_reset_n(syn_reset_n),
    .req_valid(req_valid), .req_dst_tag(req_dst_tag), .req_weight(req_weight),
    .req_ack(req_ack),
    .mem_rd_en(mem_rd_en), .mem_rd_tag(mem_rd_tag), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_tag(mem_wr_tag), .mem_wr_data(mem_wr_data),
    .busy(busy), .grant_idx(grant_idx), .sat_sticky(sat_sticky)
  );

  // i_next RAM: one-cycle read latency, bench-side preload port.
  logic [DW-1:0] mem [2];
  logic          pre_we;
  logic          pre_tag;
  logic [DW-1:0] pre_val;

  always @(posedge clk) begin
    if (pre_we) mem[pre_tag] <= pre_val;
    else if (mem_wr_en) mem[mem_wr_tag] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_tag];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    syn_reset_n = 1'b0;
    req_valid   = '0;
    @(negedge clk);
    @(negedge clk);
    syn_reset_n = 1'b1;
  endtask

  task automatic preload(input logic t, input logic [DW-1:0] v);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_tag = t;
    pre_val = v;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  task automatic set_req(input int k, input logic t, input logic [DW-1:0] w);
    req_dst_tag[k]       = t;
    req_weight[k*DW +: DW] = w;
  endtask

  // Steps negedge by negedge until req_ack is seen; cycle 1 is the first
  // negedge after the call. Also records the first rd_en cycle and the read
  // data presented in the cycle after it.
  task automatic wait_ack(output int cyc, output int rd_cyc, output logic [NREQ-1:0] ack,
                          output logic tag, output logic [DW-1:0] data,
                          output logic [DW-1:0] rdd);
    logic found;
    found  = 1'b0;
    cyc    = 0;
    rd_cyc = -1;
    ack    = '0;
    tag    = 1'b0;
    data   = '0;
    rdd    = '0;
    while (!found && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_rd_en && rd_cyc < 0) rd_cyc = cyc;
      if (rd_cyc >= 0 && cyc == rd_cyc + 1) rdd = mem_rd_data;
      if (req_ack != '0) begin
        found = 1'b1;
        ack   = req_ack;
        tag   = mem_wr_tag;
        data  = mem_wr_data;
      end
    end
    check("ack_seen", 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int               cyc, rd_cyc;
  logic [NREQ-1:0]  ack;
  logic             wtag;
  logic [DW-1:0]    wdata, rdd;

  initial begin
    syn_reset_n = 1'b0;
    req_valid   = '0;
    req_dst_tag = '0;
    req_weight  = '0;
    pre_we      = 1'b0;
    pre_tag     = 1'b0;
    pre_val     = '0;
    mem_rd_data = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_ack",     32'(req_ack),     32'd0);
    check("rst_rd_en",   32'(mem_rd_en),   32'd0);
    check("rst_wr_en",   32'(mem_wr_en),   32'd0);
    check("rst_grant",   32'(grant_idx),   32'd0);
    check("rst_sat",     32'(sat_sticky),  32'd0);
    check("rst_wr_data", 32'(mem_wr_data), 32'd0);
    syn_reset_n = 1'b1;

    // Single request: 100 + (-30) = 70 on tag 1 by requester 2
    preload(1'b1, 16'd100);
    set_req(2, 1'b1, 16'(-30));
    req_valid = 4'b0100;
    wait_ack(cyc, rd_cyc, ack, wtag, wdata, rdd);
    check("single_rd_cyc", 32'(rd_cyc), 32'd1);
    check("single_ack_cyc", 32'(cyc), 32'd3);
    check("single_ack", 32'(ack), 32'b0100);
    check("single_wr_tag", 32'(wtag), 32'd1);
    check("single_wr_data", int'($signed(wdata)), 32'd70);
    check("single_rd_data", int'($signed(rdd)), 32'd100);
    check("single_grant", 32'(grant_idx), 32'd2);
    req_valid = '0;
    @(negedge clk);
    check("single_busy_after", 32'(busy), 32'd0);
    check("single_mem", int'($signed(mem[1])), 32'd70);
    check("single_no_sat", 32'(sat_sticky), 32'd0);

    // Positive then negative saturation
    preload(1'b0, 16'd32760);
    set_req(0, 1'b0, 16'd100);
    req_valid = 4'b0001;
    wait_ack(cyc, rd_cyc, ack, wtag, wdata, rdd);
    check("satp_data", int'($signed(wdata)), 32'd32767);
    check("satp_sticky", 32'(sat_sticky), 32'd1);
    req_valid = '0;
    @(negedge clk);
    preload(1'b0, 16'(-32760));
    set_req(0, 1'b0, 16'(-100));
    req_valid = 4'b0001;
    wait_ack(cyc, rd_cyc, ack, wtag, wdata, rdd);
    check("satn_data", int'($signed(wdata)), -32768);
    check("satn_sticky", 32'(sat_sticky), 32'd1);
    req_valid = '0;
    @(negedge clk);

    // Round robin: four requesters, weight 1 on tag 0, eight acks
    do_reset();
    preload(1'b0, 16'd0);
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b0, 16'd1);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_ack(cyc, rd_cyc, ack, wtag, wdata, rdd);
      check($sformatf("rr%0d_gap", k), 32'(cyc), 32'd3);
      check($sformatf("rr%0d_grant", k), 32'(grant_idx), 32'(k % 4));
      check($sformatf("rr%0d_ack", k), 32'(ack), 32'(1 << (k % 4)));
      check($sformatf("rr%0d_data", k), int'($signed(wdata)), 32'(k + 1));
      if (k == 7) req_valid = '0;
    end
    @(negedge clk);
    check("rr_busy_after", 32'(busy), 32'd0);
    check("rr_mem", int'($signed(mem[0])), 32'd8);

    // Same-tag serialization: 10 +5 (req 0) then +7 (req 3)
    do_reset();
    preload(1'b1, 16'd10);
    set_req(0, 1'b1, 16'd5);
    set_req(3, 1'b1, 16'd7);
    req_valid = 4'b1001;
    wait_ack(cyc, rd_cyc, ack, wtag, wdata, rdd);
    check("ser1_ack", 32'(ack), 32'b0001);
    check("ser1_rd", int'($signed(rdd)), 32'd10);
    check("ser1_data", int'($signed(wdata)), 32'd15);
    req_valid = 4'b1000;
    wait_ack(cyc, rd_cyc, ack, wtag, wdata, rdd);
    check("ser2_rd_cyc", 32'(rd_cyc), 32'd1);
    check("ser2_ack", 32'(ack), 32'b1000);
    check("ser2_rd", int'($signed(rdd)), 32'd15);
    check("ser2_data", int'($signed(wdata)), 32'd22);
    req_valid = '0;
    @(negedge clk);
    check("ser_mem", int'($signed(mem[1])), 32'd22);

    // Latched weight and masking of the acked requester
    preload(1'b0, 16'd0);
    set_req(1, 1'b0, 16'd3);
    req_valid = 4'b0010;
    @(negedge clk);
    check("stab_read", 32'(mem_rd_en), 32'd1);
    set_req(1, 1'b0, 16'd50);
    wait_ack(cyc, rd_cyc, ack, wtag, wdata, rdd);
    check("stab_ack", 32'(ack), 32'b0010);
    check("stab_data", int'($signed(wdata)), 32'd3);
    @(negedge clk);
    check("mask_idle", 32'(busy), 32'd0);
    check("mask_no_read", 32'(mem_rd_en), 32'd0);
    check("mask_grant", 32'(grant_idx), 32'd1);
    req_valid = '0;
    @(negedge clk);
    check("stab_mem", int'($signed(mem[0])), 32'd3);

    // Reset during ADD aborts the accumulation
    do_reset();
    preload(1'b1, 16'd0);
    set_req(2, 1'b1, 16'd9);
    req_valid = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check("mid_in_add", 32'(busy), 32'd1);
    syn_reset_n = 1'b0;
    @(negedge clk);
    check("mid_wr_en", 32'(mem_wr_en), 32'd0);
    check("mid_ack", 32'(req_ack), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rd_en", 32'(mem_rd_en), 32'd0);
    check("mid_grant", 32'(grant_idx), 32'd0);
    check("mid_rd_tag", 32'(mem_rd_tag), 32'd0);
    check("mid_wr_tag", 32'(mem_wr_tag), 32'd0);
    check("mid_mem", int'($signed(mem[1])), 32'd0);
    syn_reset_n = 1'b1;
    wait_ack(cyc, rd_cyc, ack, wtag, wdata, rdd);
    check("mid_rearb_cyc", 32'(cyc), 32'd3);
    check("mid_rearb_ack", 32'(ack), 32'b0100);
    check("mid_rearb_data", int'($signed(wdata)), 32'd9);
    req_valid = '0;
    @(negedge clk);
    check("mid_mem_final", int'($signed(mem[1])), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
